// File: rtl/ready_valid_pkg.sv
// Shared types and default sizing for the ready/valid arbiter family.
package ready_valid_pkg;

  typedef enum logic {
    READY_VALID_ARB_IDLE,
    READY_VALID_ARB_GRANTED
  } ready_valid_arb_state;

  localparam int unsigned DEF_N_MASTERS  = 4;
  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_MAX_BURST  = 4;

endpackage

// File: rtl/ready_valid_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: first requester after 'last' in cyclic order.
module rr_priority_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] winner,
  output logic             any_req
);

  logic [IDX_W-1:0] idx;
  logic             found;

  // Scan last+1 .. last+N_REQ (wrapping); the first hit wins, 'last' itself is checked last.
  always_comb begin
    winner = last;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      idx = IDX_W'((32'(last) + off) % N_REQ);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/ready_valid_arbiter.sv
// Round-robin arbiter sharing one ready/valid slave among N masters, with bounded bursts.
module ready_valid_arbiter
  import ready_valid_pkg::*;
#(
  parameter int unsigned N_MASTERS  = DEF_N_MASTERS,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned MAX_BURST  = DEF_MAX_BURST,
  localparam int unsigned IW        = $clog2(N_MASTERS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_MASTERS*DATA_WIDTH-1:0] m_data,
  input  logic [N_MASTERS-1:0]            m_valid,
  output logic [N_MASTERS-1:0]            m_ready,
  output logic [DATA_WIDTH-1:0]           s_data,
  output logic                            s_valid,
  input  logic                            s_ready,
  output logic [IW-1:0]                   grant_id,
  output logic                            grant_active
);

  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  ready_valid_arb_state state_q, state_d;
  logic [IW-1:0]        grant_q, grant_d;
  logic [CW-1:0]        beat_cnt_q, beat_cnt_d;
  logic [IW-1:0]        pick_idx;
  logic                 pick_any;
  logic [DATA_WIDTH-1:0] data_arr [N_MASTERS];
  logic                 gnt_valid;
  logic                 beat;
  logic                 last_beat;

  // Unpack the flat payload bus into per-master lanes.
  for (genvar g = 0; g < N_MASTERS; g++) begin : g_lane
    assign data_arr[g] = m_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_priority_pick #(
    .N_REQ (N_MASTERS),
    .IDX_W (IW)
  ) u_pick (
    .req     (m_valid),
    .last    (grant_q),
    .winner  (pick_idx),
    .any_req (pick_any)
  );

  assign gnt_valid = m_valid[grant_q];
  assign beat      = (state_q == READY_VALID_ARB_GRANTED) && gnt_valid && s_ready;
  assign last_beat = (beat_cnt_q == CW'(MAX_BURST - 1));

  // State, grant and beat counter registers; reset parks grant on the last master.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= READY_VALID_ARB_IDLE;
      grant_q    <= IW'(N_MASTERS - 1);
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Next state: arbitrate in IDLE, count beats and release on burst limit or valid drop.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      READY_VALID_ARB_IDLE: begin
        if (pick_any) begin
          grant_d    = pick_idx;
          beat_cnt_d = '0;
          state_d    = READY_VALID_ARB_GRANTED;
        end
      end
      READY_VALID_ARB_GRANTED: begin
        if (beat) begin
          beat_cnt_d = beat_cnt_q + CW'(1);
        end
        if ((beat && last_beat) || !gnt_valid) begin
          state_d = READY_VALID_ARB_IDLE;
        end
      end
      default: state_d = READY_VALID_ARB_IDLE;
    endcase
  end

  // Outputs: zero-latency mux of the granted master; everything quiet in IDLE.
  always_comb begin
    s_valid      = 1'b0;
    s_data       = '0;
    m_ready      = '0;
    grant_active = 1'b0;
    if (state_q == READY_VALID_ARB_GRANTED) begin
      s_valid          = gnt_valid;
      s_data           = data_arr[grant_q];
      m_ready[grant_q] = s_ready;
      grant_active     = 1'b1;
    end
  end

  assign grant_id = grant_q;

endmodule

// File: tb/tb_ready_valid_arbiter.sv
// Randomized bench for ready_valid_arbiter: lane 0 uses MAX_BURST=4, lane 1 MAX_BURST=1.
module tb_ready_valid_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = 2;
  localparam int L  = 2;

  logic          clk;
  logic          rst;
  logic [N*DW-1:0] m_data [L];
  logic [N-1:0]  m_valid [L];
  logic [N-1:0]  m_ready [L];
  logic [DW-1:0] s_data [L];
  logic          s_valid [L];
  logic          s_ready [L];
  logic [IW-1:0] grant_id [L];
  logic          grant_active [L];

  ready_valid_arbiter #(.N_MASTERS(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut0 (
    .clk(clk), .rst(rst), .m_data(m_data[0]), .m_valid(m_valid[0]), .m_ready(m_ready[0]),
    .s_data(s_data[0]), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
    .grant_id(grant_id[0]), .grant_active(grant_active[0]));

  ready_valid_arbiter #(.N_MASTERS(4), .DATA_WIDTH(8), .MAX_BURST(1)) dut1 (
    .clk(clk), .rst(rst), .m_data(m_data[1]), .m_valid(m_valid[1]), .m_ready(m_ready[1]),
    .s_data(s_data[1]), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
    .grant_id(grant_id[1]), .grant_active(grant_active[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;
  int unsigned drop_pct;
  int unsigned ready_pct;

  // pending beats per (lane, master) as seen by the reference model
  logic [DW-1:0] src_q [L*N][$];
  // expected downstream order per (lane, master) for the scoreboard
  logic [DW-1:0] exp_q [L*N][$];
  bit            rdy_q [L][$];
  int            grant_log [L][$];
  int            beat_log [L][$];
  logic [15:0]   hist [L];
  logic          prev_active [L];

  // reference model: who owns the bus and how many beats it has moved
  bit busy [L];
  int owner [L];
  int cnt [L];

  function automatic int limit(input int l);
    return (l == 0) ? 4 : 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic load(input int l, input int i, input int n);
    logic [DW-1:0] b;
    repeat (n) begin
      b = DW'($urandom);
      src_q[l*N+i].push_back(b);
      exp_q[l*N+i].push_back(b);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < L; l++) begin
      busy[l] = 1'b0;
      owner[l] = N - 1;
      cnt[l] = 0;
      prev_active[l] = 1'b0;
      hist[l] = '0;
      grant_log[l].delete();
      beat_log[l].delete();
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    for (int l = 0; l < L; l++) begin
      check({pfx, "_svalid"}, 32'(s_valid[l]), 0);
      check({pfx, "_mready"}, 32'(m_ready[l]), 0);
      check({pfx, "_gid"}, 32'(grant_id[l]), N - 1);
      check({pfx, "_active"}, 32'(grant_active[l]), 0);
    end
  endtask

  task automatic do_reset();
    for (int k = 0; k < L*N; k++) begin
      src_q[k].delete();
      exp_q[k].delete();
    end
    for (int l = 0; l < L; l++) begin
      rdy_q[l].delete();
      m_valid[l] = '0;
      m_data[l] = '0;
      s_ready[l] = 1'b0;
    end
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    check_reset_outputs("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_drained(input string tag);
    int pend;
    pend = 0;
    for (int k = 0; k < L*N; k++) pend += exp_q[k].size();
    check(tag, 32'(pend), 0);
  endtask

  // One clock: drive, compare against the model, record, then advance the model at the edge.
  task automatic step();
    logic [N-1:0] er;
    bit           ev;
    bit           bt;
    int           o;
    int           g;
    bit           found;
    for (int l = 0; l < L; l++) begin
      for (int i = 0; i < N; i++) begin
        m_valid[l][i] = (src_q[l*N+i].size() != 0) && ($urandom_range(99) >= drop_pct);
        m_data[l][i*DW +: DW] = m_valid[l][i] ? src_q[l*N+i][0] : DW'($urandom);
      end
      if (rdy_q[l].size() != 0) s_ready[l] = rdy_q[l].pop_front();
      else s_ready[l] = ($urandom_range(99) < ready_pct);
    end
    #3;
    for (int l = 0; l < L; l++) begin
      o  = owner[l];
      er = '0;
      ev = 1'b0;
      if (busy[l]) begin
        ev    = m_valid[l][o];
        er[o] = s_ready[l];
      end
      check("s_valid", 32'(s_valid[l]), 32'(ev));
      check("m_ready", 32'(m_ready[l]), 32'(er));
      check("grant_id", 32'(grant_id[l]), 32'(o));
      check("grant_active", 32'(grant_active[l]), 32'(busy[l]));
      if (ev) check("s_data", 32'(s_data[l]), 32'(src_q[l*N+o][0]));
      if (grant_active[l] && !prev_active[l]) grant_log[l].push_back(int'(grant_id[l]));
      prev_active[l] = grant_active[l];
      bt = s_valid[l] && s_ready[l];
      hist[l] = {hist[l][14:0], bt};
      if (bt) begin
        g = int'(grant_id[l]);
        beat_log[l].push_back(g);
        check("sb_avail", 32'(exp_q[l*N+g].size() != 0), 1);
        if (exp_q[l*N+g].size() != 0) check("sb_data", 32'(s_data[l]), 32'(exp_q[l*N+g].pop_front()));
      end
    end
    @(posedge clk);
    for (int l = 0; l < L; l++) begin
      o = owner[l];
      if (busy[l]) begin
        if (m_valid[l][o] && s_ready[l]) begin
          void'(src_q[l*N+o].pop_front());
          cnt[l]++;
          if (cnt[l] == limit(l)) busy[l] = 1'b0;
        end else if (!m_valid[l][o]) begin
          busy[l] = 1'b0;
        end
      end else if (m_valid[l] != '0) begin
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          if (!found && m_valid[l][(o + k) % N]) begin
            found = 1'b1;
            owner[l] = (o + k) % N;
          end
        end
        busy[l] = 1'b1;
        cnt[l] = 0;
      end
    end
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    drop_pct = 0;
    ready_pct = 100;

    // single requester, 6 beats: 4-beat burst, bubble, 2-beat burst, release
    do_reset();
    load(0, 0, 6);
    repeat (10) step();
    check("t1_pattern", 32'(hist[0][9:0]), 32'(10'b0111101100));
    check("t1_first_gid", 32'(grant_log[0].size() > 0 ? grant_log[0][0] : -1), 0);
    check_drained("t1_drain");

    // all four requesting continuously: fair rotation 0,1,2,3,0
    do_reset();
    for (int i = 0; i < N; i++) load(0, i, 8);
    repeat (45) step();
    check("t2_ngrants", 32'(grant_log[0].size()), 8);
    for (int j = 0; j < 5; j++)
      check("t2_order", 32'(grant_log[0].size() > j ? grant_log[0][j] : -1), 32'(j % N));
    check_drained("t2_drain");

    // backpressure mid-burst on master 2: grant held, burst completes with 3 more beats
    do_reset();
    load(0, 2, 4);
    rdy_q[0] = '{1, 1, 0, 0, 0, 0, 0};
    repeat (14) step();
    check("t3_one_grant", 32'(grant_log[0].size()), 1);
    check("t3_beats", 32'(beat_log[0].size()), 4);
    check_drained("t3_drain");

    // early drop: master 1 sends 2 then drops valid, waiting master 3 follows
    do_reset();
    load(0, 1, 2);
    load(0, 3, 4);
    repeat (12) step();
    check("t4_ngrants", 32'(grant_log[0].size()), 2);
    check("t4_first", 32'(grant_log[0].size() > 0 ? grant_log[0][0] : -1), 1);
    check("t4_second", 32'(grant_log[0].size() > 1 ? grant_log[0][1] : -1), 3);
    check_drained("t4_drain");

    // asynchronous reset between edges mid-burst, then master 0 wins first
    do_reset();
    for (int i = 0; i < N; i++) load(0, i, 6);
    repeat (6) step();
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("arst");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (60) step();
    check("t5_first_gid", 32'(grant_log[0].size() > 0 ? grant_log[0][0] : -1), 0);
    check_drained("t5_drain");

    // MAX_BURST=1 lane: masters 0 and 1 alternate with a bubble between every beat
    do_reset();
    load(1, 0, 3);
    load(1, 1, 3);
    repeat (12) step();
    check("t6_pattern", 32'(hist[1][11:0]), 32'(12'b010101010101));
    for (int j = 0; j < 6; j++)
      check("t6_order", 32'(beat_log[1].size() > j ? beat_log[1][j] : -1), 32'(j % 2));
    check_drained("t6_drain");

    // random traffic on both lanes with backpressure and valid drops, then drain
    do_reset();
    ready_pct = 70;
    drop_pct = 10;
    repeat (6) begin
      for (int l = 0; l < L; l++)
        for (int i = 0; i < N; i++) load(l, i, int'($urandom_range(8)));
      repeat (50) step();
    end
    ready_pct = 100;
    drop_pct = 0;
    repeat (600) step();
    check_drained("rand_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
